ldm_writeback_seq: RTL and testbench

//  Write-back stage sequencer that drives the register file write port (write_en/addr/data).

---
 rtl/ldm_writeback_seq.sv | 125 ++++++++++++
 tb/tb_ldm_writeback_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_writeback_seq.sv
// Write-back sequencer: routes single ALU/load results and expands LDM/POP register
// lists into ascending per-beat register writes, diverting r15 to the PC port.
module ldm_writeback_seq #(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LIST_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_valid_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WORD-1:0]       wb_data_i,
  input  logic                  multi_start_i,
  input  logic [LIST_WIDTH-1:0] multi_list_i,
  input  logic                  mem_valid_i,
  input  logic [WORD-1:0]       mem_data_i,
  output logic                  mem_ready_o,
  output logic                  stall_o,
  output logic                  reg_write_en_o,
  output logic [ADDR_WIDTH-1:0] reg_write_addr_o,
  output logic [WORD-1:0]       reg_write_data_o,
  output logic                  pc_write_en_o,
  output logic [WORD-1:0]       pc_write_data_o,
  output logic                  done_o,
  output logic                  protocol_err_o
);
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(15);

  typedef enum logic {S_IDLE, S_MULTI} state_t;

  state_t                r_state;
  logic [LIST_WIDTH-1:0] r_pending;
  logic                  r_reg_we, r_pc_we, r_done, r_err;
  logic [ADDR_WIDTH-1:0] r_reg_addr;
  logic [WORD-1:0]       r_reg_data, r_pc_data;

  logic [ADDR_WIDTH-1:0] w_tgt;
  logic [LIST_WIDTH-1:0] w_tgt_mask, w_rest;
  logic                  w_beat, w_wr, w_done, w_is_pc;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WORD-1:0]       w_data;

  // Lowest set bit of the pending list: scanning high-to-low leaves the lowest hit.
  always_comb begin
    w_tgt      = '0;
    w_tgt_mask = '0;
    for (int i = LIST_WIDTH-1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_tgt      = ADDR_WIDTH'(i);
        w_tgt_mask = LIST_WIDTH'(1) << i;
      end
    end
  end

  assign w_beat = (r_state == S_MULTI) && mem_valid_i;
  assign w_rest = r_pending & ~w_tgt_mask;

  always_comb begin
    w_wr   = 1'b0;
    w_addr = wb_addr_i;
    w_data = wb_data_i;
    w_done = 1'b0;
    if (r_state == S_IDLE) begin
      w_wr   = wb_valid_i;
      w_done = multi_start_i && (multi_list_i == '0);
    end else if (w_beat) begin
      w_wr   = 1'b1;
      w_addr = w_tgt;
      w_data = mem_data_i;
      w_done = (w_rest == '0);
    end
  end

  assign w_is_pc = (w_addr == PC_ADDR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_reg_we   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
      r_pc_we    <= 1'b0;
      r_pc_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_reg_we <= w_wr && !w_is_pc;
      r_pc_we  <= w_wr && w_is_pc;
      r_done   <= w_done;
      if (w_wr && !w_is_pc) begin
        r_reg_addr <= w_addr;
        r_reg_data <= w_data;
      end
      if (w_wr && w_is_pc) r_pc_data <= w_data;
      case (r_state)
        S_IDLE: begin
          if (multi_start_i && (multi_list_i != '0)) begin
            r_pending <= multi_list_i;
            r_state   <= S_MULTI;
          end
        end
        S_MULTI: begin
          // New requests during a burst are dropped, not queued.
          if (wb_valid_i || multi_start_i) r_err <= 1'b1;
          if (w_beat) begin
            r_pending <= w_rest;
            if (w_rest == '0) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ready_o      = (r_state == S_MULTI);
  assign stall_o          = (r_state == S_MULTI);
  assign reg_write_en_o   = r_reg_we;
  assign reg_write_addr_o = r_reg_addr;
  assign reg_write_data_o = r_reg_data;
  assign pc_write_en_o    = r_pc_we;
  assign pc_write_data_o  = r_pc_data;
  assign done_o           = r_done;
  assign protocol_err_o   = r_err;
endmodule

// File: tb/tb_ldm_writeback_seq.sv
// Scoreboard bench for ldm_writeback_seq: expected writes are queued with their
// due cycle as stimulus is driven, and a negedge monitor pops and compares them.
module tb_ldm_writeback_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mstart;
  logic [15:0] mlist;
  logic        mvalid;
  logic [31:0] mdata;
  logic        mem_ready, stall, ren, pen, done, perr;
  logic [3:0]  waddr;
  logic [31:0] wdata, pdata;

  ldm_writeback_seq #(.WORD(32), .ADDR_WIDTH(4), .LIST_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .multi_start_i(mstart), .multi_list_i(mlist),
    .mem_valid_i(mvalid), .mem_data_i(mdata),
    .mem_ready_o(mem_ready), .stall_o(stall),
    .reg_write_en_o(ren), .reg_write_addr_o(waddr), .reg_write_data_o(wdata),
    .pc_write_en_o(pen), .pc_write_data_o(pdata),
    .done_o(done), .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        ren;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        pen;
    logic [31:0] pdata;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected routed write (or bare done) due in the cycle after the current one.
  function automatic void push_exp(input logic wr, input logic [3:0] a,
                                   input logic [31:0] d, input logic dn);
    exp_t e;
    e.cyc = cyc + 1; e.done = dn;
    e.ren = wr && (a != 4'd15); e.addr = a; e.data = d;
    e.pen = wr && (a == 4'd15); e.pdata = d;
    q.push_back(e);
  endfunction

  exp_t m;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ren || pen || done) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_write cyc=%0d ren=%0b addr=%0d data=%h pen=%0b pdata=%h done=%0b",
                   cyc, ren, waddr, wdata, pen, pdata, done);
        end else begin
          m = q.pop_front();
          if (m.cyc == cyc && ren === m.ren && pen === m.pen && done === m.done &&
              (!m.ren || (waddr === m.addr && wdata === m.data)) &&
              (!m.pen || pdata === m.pdata))
            n_pass++;
          else
            $display("FAIL scoreboard cyc=%0d got ren=%0b a=%0d d=%h pen=%0b pd=%h done=%0b, want cyc=%0d ren=%0b a=%0d d=%h pen=%0b pd=%h done=%0b",
                     cyc, ren, waddr, wdata, pen, pdata, done,
                     m.cyc, m.ren, m.addr, m.data, m.pen, m.pdata, m.done);
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        n_total++;
        m = q.pop_front();
        $display("FAIL missing_write cyc=%0d want ren=%0b a=%0d d=%h pen=%0b done=%0b",
                 m.cyc, m.ren, m.addr, m.data, m.pen, m.done);
      end
    end
  end

  task automatic quiet();
    @(negedge clk);
    wb_valid = 0; mstart = 0; mvalid = 0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] a, input logic dn);
    @(negedge clk);
    wb_valid = 0; mstart = 0; mvalid = 1; mdata = d;
    push_exp(1'b1, a, d, dn);
  endtask

  task automatic test_reset();
    rst_n = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
    mstart = 0; mlist = 0; mvalid = 0; mdata = 0;
    #12;
    n_total++;
    if ({ren, pen, done, perr, mem_ready, stall, waddr, wdata, pdata} !== '0)
      $display("FAIL reset_outputs got %h required 0",
               {ren, pen, done, perr, mem_ready, stall, waddr, wdata, pdata});
    else n_pass++;
    @(negedge clk); rst_n = 1;
    repeat (2) quiet();
  endtask

  task automatic test_single();
    @(negedge clk);
    wb_valid = 1; wb_addr = 4'd3; wb_data = 32'hDEADBEEF;
    push_exp(1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
    quiet();
    quiet();
    n_total++;
    if (ren !== 1'b0 || waddr !== 4'd3 || wdata !== 32'hDEADBEEF)
      $display("FAIL single_hold got en=%0b a=%0d d=%h required en=0 a=3 d=deadbeef", ren, waddr, wdata);
    else n_pass++;
    // r15 via the single path goes to the PC port.
    @(negedge clk);
    wb_valid = 1; wb_addr = 4'd15; wb_data = 32'h0000_4000;
    push_exp(1'b1, 4'd15, 32'h0000_4000, 1'b0);
    repeat (2) quiet();
  endtask

  task automatic test_ldm_gap();
    @(negedge clk);
    mstart = 1; mlist = 16'h0085;
    @(negedge clk);
    mstart = 0;
    n_total++;
    if (stall !== 1'b1 || mem_ready !== 1'b1)
      $display("FAIL ldm_stall_start got stall=%0b ready=%0b required 1/1", stall, mem_ready);
    else n_pass++;
    mvalid = 1; mdata = 32'h11; push_exp(1'b1, 4'd0, 32'h11, 1'b0);
    quiet();
    n_total++;
    if (stall !== 1'b1)
      $display("FAIL ldm_stall_gap got %0b required 1", stall);
    else n_pass++;
    beat(32'h22, 4'd2, 1'b0);
    beat(32'h33, 4'd7, 1'b1);
    quiet();
    n_total++;
    if (stall !== 1'b0 || mem_ready !== 1'b0)
      $display("FAIL ldm_stall_end got stall=%0b ready=%0b required 0/0", stall, mem_ready);
    else n_pass++;
    repeat (2) quiet();
  endtask

  task automatic test_pop_pc();
    @(negedge clk);
    mstart = 1; mlist = 16'h8003;
    beat(32'hA, 4'd0, 1'b0);
    beat(32'hB, 4'd1, 1'b0);
    beat(32'h100, 4'd15, 1'b1);
    quiet();
    n_total++;
    if (ren !== 1'b0 || pen !== 1'b1 || pdata !== 32'h100 || done !== 1'b1)
      $display("FAIL pop_pc got ren=%0b pen=%0b pd=%h done=%0b required 0/1/100/1", ren, pen, pdata, done);
    else n_pass++;
    repeat (2) quiet();
  endtask

  task automatic test_empty_list();
    logic seen = 1'b0;
    @(negedge clk);
    mstart = 1; mlist = 16'h0000;
    push_exp(1'b0, 4'd0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      quiet();
      seen |= stall | mem_ready;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL empty_list_stall got 1 required 0");
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wb_valid = 1; wb_addr = 4'd5; wb_data = 32'h55;
    mstart = 1; mlist = 16'h0002;
    push_exp(1'b1, 4'd5, 32'h55, 1'b0);
    beat(32'h66, 4'd1, 1'b1);
    repeat (3) quiet();
    n_total++;
    if (perr !== 1'b0) $display("FAIL b2b_no_err got %0b required 0", perr);
    else n_pass++;
  endtask

  task automatic test_reset_midburst();
    @(negedge clk);
    mstart = 1; mlist = 16'h00F0;
    beat(32'h40, 4'd4, 1'b0);
    beat(32'h50, 4'd5, 1'b0);
    @(negedge clk);
    mdata = 32'h60;
    #2 rst_n = 0;
    #1;
    q.delete();
    n_total++;
    if ({ren, pen, done, perr, mem_ready, stall, waddr, wdata, pdata} !== '0)
      $display("FAIL async_reset got %h required 0",
               {ren, pen, done, perr, mem_ready, stall, waddr, wdata, pdata});
    else n_pass++;
    @(negedge clk); mvalid = 0;
    @(negedge clk); rst_n = 1;
    // Leftover beats after reset must not produce writes.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mvalid = 1; mdata = 32'h70 + i;
    end
    n_total++;
    if (mem_ready !== 1'b0 || stall !== 1'b0 || perr !== 1'b0)
      $display("FAIL idle_beats got ready=%0b stall=%0b err=%0b required 0/0/0", mem_ready, stall, perr);
    else n_pass++;
    quiet();
  endtask

  task automatic test_protocol_err();
    @(negedge clk);
    mstart = 1; mlist = 16'h0003;
    beat(32'h1, 4'd0, 1'b0);
    @(negedge clk);
    mvalid = 0; wb_valid = 1; wb_addr = 4'd9; wb_data = 32'h99;
    quiet();
    n_total++;
    if (perr !== 1'b1) $display("FAIL perr_set got %0b required 1", perr);
    else n_pass++;
    beat(32'h2, 4'd1, 1'b1);
    repeat (3) quiet();
    n_total++;
    if (perr !== 1'b1 || stall !== 1'b0)
      $display("FAIL perr_sticky got err=%0b stall=%0b required 1/0", perr, stall);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ldm_gap();
    test_pop_pc();
    test_empty_list();
    test_back_to_back();
    test_reset_midburst();
    test_protocol_err();
    repeat (2) quiet();
    n_total++;
    if (q.size() != 0) $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
